// File: rtl/counter_defs.sv
// Shared constants and parameter legality check
// for the modulo-N counter family.
package counter_defs;

  localparam bit CNT_DOWN = 1'b0;
  localparam bit CNT_UP   = 1'b1;
  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  function automatic bit params_ok(
    input int width,
    input longint modulus,
    input longint reset_val
  );
    longint span;
    if (width < 1 || width > 30) return 1'b0;
    span = longint'(1) << width;
    return (modulus >= 2) && (modulus <= span) &&
           (reset_val >= 0) && (reset_val < modulus);
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Next-state logic for mod_n_counter: load clamp,
// up/down step, wrap/saturate at terminal count.
module mod_n_next
  import counter_defs::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] ps_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] ns_o,
  output logic             wrap_o,
  output logic             tc_o
);

  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ZERO  = '0;

  logic [WIDTH:0] ps_x;
  logic [WIDTH:0] lv_x;
  logic [WIDTH:0] nx;

  assign ps_x = {1'b0, ps_i};
  assign lv_x = {1'b0, load_val_i};
  assign tc_o = (up_i == CNT_UP) ? (ps_x == MAX_X)
                                 : (ps_x == ZERO);

  always_comb begin
    nx     = ps_x;
    wrap_o = 1'b0;
    if (load_i) begin
      nx = (lv_x < MOD_X) ? lv_x : MAX_X;
    end else if (en_i) begin
      if (!tc_o) begin
        nx = (up_i == CNT_UP) ? ps_x + 1'b1
                              : ps_x - 1'b1;
      end else if (sat_i == CNT_WRAP) begin
        nx     = (up_i == CNT_UP) ? ZERO : MAX_X;
        wrap_o = 1'b1;
      end
    end
  end

  // Range guard keeps OUT legal even from a corrupted state.
  assign ns_o = (nx > MAX_X) ? MAX_X[WIDTH-1:0]
                             : nx[WIDTH-1:0];

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N counter: OUT and WRAP
// registers with synchronous reset.
module mod_n_counter
  import counter_defs::*;
#(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             WRAP
);

  if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_bad
    $error("mod_n_counter: illegal WIDTH/MODULUS/RESET_VAL");
  end

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  mod_n_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .ps_i       (out_q),
    .up_i       (UP),
    .sat_i      (SAT),
    .en_i       (EN),
    .load_i     (LOAD),
    .load_val_i (LOAD_VAL),
    .ns_o       (out_d),
    .wrap_o     (wrap_d),
    .tc_o       (TC)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      out_q  <= RST_V;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign OUT  = out_q;
  assign WRAP = wrap_q;

endmodule
